// File: rtl/gpi_debounce.sv
// Two-flop synchroniser plus per-bit stability counter for board switch inputs.
// Optional rise/fall pulse outputs are built when GPI_DEBOUNCE_EDGE_EN is defined.
module gpi_debounce #(
  parameter int               Width      = 13,
  parameter int               Threshold  = 4,
  parameter int               CntWidth   = 8,
  parameter int               Prescale   = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  input  logic [Width-1:0] in_i,
  output logic [Width-1:0] deb_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o
);

  localparam logic [15:0]         PreMax = 16'(Prescale - 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(Threshold - 1);

  logic [Width-1:0]    s1, s2;
  logic [Width-1:0]    deb_q;
  logic [Width-1:0]    dis, upd;
  logic [15:0]         pre_cnt;
  logic                tick;
  logic [CntWidth-1:0] cnt [Width];

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      s1 <= ResetValue;
      s2 <= ResetValue;
    end else begin
      s1 <= in_i;
      s2 <= s1;
    end
  end

  // With Prescale=1 PreMax is 0, so tick stays high and the counter never leaves 0.
  assign tick = (pre_cnt == PreMax);

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 16'd1;
    end
  end

  always_comb begin
    dis = '0;
    upd = '0;
    for (int unsigned i = 0; i < Width; i++) begin
      dis[i] = s2[i] ^ deb_q[i];
      upd[i] = dis[i] & tick & (cnt[i] == CntMax);
    end
  end

  // Any cycle where the synchronised level agrees with the output clears the count.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      deb_q <= ResetValue;
      for (int unsigned i = 0; i < Width; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < Width; i++) begin
        if (!dis[i]) begin
          cnt[i] <= '0;
        end else if (upd[i]) begin
          cnt[i]   <= '0;
          deb_q[i] <= s2[i];
        end else if (tick) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign deb_o = deb_q;

`ifdef GPI_DEBOUNCE_EDGE_EN
  logic [Width-1:0] rise_q, fall_q;

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= upd & s2;
      fall_q <= upd & ~s2;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = '0;
  assign fall_o = '0;
`endif

endmodule

// File: tb/tb_gpi_debounce.sv
// Bench for gpi_debounce: per-cycle vector tables for the default configuration
// and a second instance with Prescale=10, Threshold=3 for the slow-tick cases.
module tb_gpi_debounce;

`ifdef GPI_DEBOUNCE_EDGE_EN
  localparam bit EdgeEn = 1'b1;
`else
  localparam bit EdgeEn = 1'b0;
`endif

  typedef struct {
    logic [12:0] in_v;
    logic [12:0] deb;
    logic [12:0] rise;
    logic [12:0] fall;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] in_a = '0, in_b = '0;
  logic [12:0] deb_a, rise_a, fall_a;
  logic [12:0] deb_b, rise_b, fall_b;

  int compared = 0;
  int mismatched = 0;

  vec_t vecs[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  gpi_debounce dut_a (
    .clk_sys_i (clk),
    .rst_sys_ni(rst_n),
    .in_i      (in_a),
    .deb_o     (deb_a),
    .rise_o    (rise_a),
    .fall_o    (fall_a)
  );

  gpi_debounce #(
    .Threshold(3),
    .Prescale (10)
  ) dut_b (
    .clk_sys_i (clk),
    .rst_sys_ni(rst_n),
    .in_i      (in_b),
    .deb_o     (deb_b),
    .rise_o    (rise_b),
    .fall_o    (fall_b)
  );

  function automatic void add(logic [12:0] iv, logic [12:0] d, logic [12:0] r, logic [12:0] f);
    vec_t v;
    v.in_v = iv;
    v.deb  = d;
    v.rise = EdgeEn ? r : 13'h0;
    v.fall = EdgeEn ? f : 13'h0;
    vecs.push_back(v);
  endfunction

  function automatic void add_run(logic [12:0] iv, logic [12:0] d, logic [12:0] r,
                                  logic [12:0] f, int n);
    for (int k = 0; k < n; k++) add(iv, d, r, f);
  endfunction

  task automatic check_a(input string name, input int idx, input vec_t e);
    compared++;
    if (deb_a !== e.deb || rise_a !== e.rise || fall_a !== e.fall) begin
      mismatched++;
      $display("FAIL %s step %0d: got deb=%h rise=%h fall=%h, want deb=%h rise=%h fall=%h",
               name, idx, deb_a, rise_a, fall_a, e.deb, e.rise, e.fall);
    end
  endtask

  // Called at a negedge; each entry is driven there and checked just after the next posedge.
  task automatic run_vectors(input string name);
    for (int k = 0; k < vecs.size(); k++) begin
      in_a = vecs[k].in_v;
      exp_q.push_back(vecs[k]);
      @(posedge clk);
      #1;
      check_a(name, k, exp_q.pop_front());
      @(negedge clk);
    end
    vecs.delete();
  endtask

  task automatic do_reset(input logic [12:0] v);
    rst_n = 1'b0;
    in_a  = v;
    in_b  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t z;
    int   lat;
    bit   bad;

    z.in_v = '0; z.deb = '0; z.rise = '0; z.fall = '0;

    // Reset held with all inputs high
    in_a = 13'h1FFF;
    repeat (3) @(negedge clk);
    check_a("reset_hold", 0, z);
    compared++;
    if (deb_b !== 13'h0 || rise_b !== 13'h0 || fall_b !== 13'h0) begin
      mismatched++;
      $display("FAIL reset_hold_b: got deb=%h rise=%h fall=%h, want 0", deb_b, rise_b, fall_b);
    end
    rst_n = 1'b1;
    add_run(13'h1FFF, 13'h0000, 13'h0000, 13'h0, 5);
    add(13'h1FFF, 13'h1FFF, 13'h1FFF, 13'h0);
    add_run(13'h1FFF, 13'h1FFF, 13'h0000, 13'h0, 2);
    run_vectors("reset_release");

    do_reset('0);
    // 3-cycle glitch on bit 0
    add_run(13'h0001, 13'h0, 13'h0, 13'h0, 3);
    add_run(13'h0000, 13'h0, 13'h0, 13'h0, 7);
    // 4-cycle pulse on bit 0
    add_run(13'h0001, 13'h0, 13'h0, 13'h0, 4);
    add(13'h0000, 13'h0000, 13'h0000, 13'h0000);
    add(13'h0000, 13'h0001, 13'h0001, 13'h0000);
    add_run(13'h0000, 13'h0001, 13'h0000, 13'h0000, 3);
    add(13'h0000, 13'h0000, 13'h0000, 13'h0001);
    add_run(13'h0000, 13'h0000, 13'h0000, 13'h0000, 2);
    // Bounce on bit 5 then hold, then release
    add(13'h0020, 13'h0, 13'h0, 13'h0);
    add(13'h0000, 13'h0, 13'h0, 13'h0);
    add(13'h0020, 13'h0, 13'h0, 13'h0);
    add(13'h0000, 13'h0, 13'h0, 13'h0);
    add(13'h0020, 13'h0, 13'h0, 13'h0);
    add_run(13'h0020, 13'h0000, 13'h0000, 13'h0, 4);
    add(13'h0020, 13'h0020, 13'h0020, 13'h0);
    add_run(13'h0020, 13'h0020, 13'h0000, 13'h0, 2);
    add_run(13'h0000, 13'h0020, 13'h0, 13'h0000, 5);
    add(13'h0000, 13'h0000, 13'h0, 13'h0020);
    add(13'h0000, 13'h0000, 13'h0, 13'h0000);
    // Bits 3 and 9 together, then released two cycles apart
    add_run(13'h0208, 13'h0000, 13'h0000, 13'h0, 5);
    add(13'h0208, 13'h0208, 13'h0208, 13'h0);
    add(13'h0208, 13'h0208, 13'h0000, 13'h0);
    add_run(13'h0008, 13'h0208, 13'h0, 13'h0000, 2);
    add_run(13'h0000, 13'h0208, 13'h0, 13'h0000, 3);
    add(13'h0000, 13'h0008, 13'h0, 13'h0200);
    add(13'h0000, 13'h0008, 13'h0, 13'h0000);
    add(13'h0000, 13'h0000, 13'h0, 13'h0008);
    add(13'h0000, 13'h0000, 13'h0, 13'h0000);
    run_vectors("pattern");

    // Bit 12 settles while bit 1 is two counts into its pending window
    do_reset('0);
    add_run(13'h1000, 13'h0000, 13'h0000, 13'h0, 2);
    add_run(13'h1002, 13'h0000, 13'h0000, 13'h0, 3);
    add(13'h1002, 13'h1000, 13'h1000, 13'h0);
    run_vectors("pre_async");
    rst_n = 1'b0;
    #1;
    check_a("async_reset", 0, z);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    add_run(13'h1002, 13'h0000, 13'h0000, 13'h0, 5);
    add(13'h1002, 13'h1002, 13'h1002, 13'h0);
    add(13'h1002, 13'h1002, 13'h0000, 13'h0);
    run_vectors("after_async");

    // Prescale=10, Threshold=3: step on bit 12
    in_b = 13'h1000;
    lat  = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (deb_b[12] === 1'b1) begin
        lat = n;
        break;
      end
    end
    compared++;
    if (lat < 23 || lat > 32) begin
      mismatched++;
      $display("FAIL prescale_latency: got %0d edges (0 = timeout), want 23..32", lat);
    end

    // 15-cycle pulse on bit 11 spans at most two ticks
    @(negedge clk);
    in_b = 13'h1800;
    bad  = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (n == 15) in_b = 13'h1000;
      @(posedge clk);
      #1;
      if (deb_b[11] !== 1'b0 || rise_b[11] !== 1'b0 || fall_b !== 13'h0) bad = 1'b1;
      @(negedge clk);
    end
    compared++;
    if (bad) begin
      mismatched++;
      $display("FAIL prescale_glitch: got bit 11 activity, want deb/rise bit 11 = 0");
    end
    compared++;
    if (deb_b !== 13'h1000) begin
      mismatched++;
      $display("FAIL prescale_final: got deb=%h, want 1000", deb_b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
